// File: rtl/program_memory_mp.sv
// Program memory filled from a byte stream, then served to several read ports
// through a round-robin arbiter over a single-ported synchronous array.
module program_memory_mp #(
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 1024,
    parameter int NUM_PORTS  = 2,
    parameter int BIG_ENDIAN = 0,
    parameter int RST_CYCLES = 1
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              byte_valid_in,
    input  logic [7:0]                        byte_in,
    input  logic                              load_done_in,
    output logic                              sys_rst_out,
    output logic [$clog2(DEPTH):0]            loaded_words_out,
    output logic                              load_error_out,
    input  logic [NUM_PORTS-1:0]              req_in,
    input  logic [NUM_PORTS*32-1:0]           addr_in,
    output logic [NUM_PORTS*WORD_BYTES*8-1:0] instr_out,
    output logic [NUM_PORTS-1:0]              valid_out
);

    localparam int WORD_W = WORD_BYTES * 8;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int OFF_W  = $clog2(WORD_BYTES);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {LOADING, FLUSH, SYS_RESET, SERVING} state_t;

    state_t              state_q, state_d;
    logic [3:0]          lane_q, lane_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]    loaded_q, loaded_d;
    logic                err_q, err_d;
    logic [31:0]         rcnt_q, rcnt_d;
    logic [PORT_W-1:0]   prio_q, prio_d;
    logic [NUM_PORTS-1:0] vld_q, vld_d;
    logic                oor_q, oor_d;
    logic [WORD_W-1:0]   hold_q [NUM_PORTS];
    logic [WORD_W-1:0]   hold_d [NUM_PORTS];

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [WORD_W-1:0]   rdata_q;
    logic                mem_we;
    logic                mem_re;
    logic [IDX_W-1:0]    mem_addr;
    logic [WORD_W-1:0]   mem_wdata;

    logic                full;
    logic [WORD_W-1:0]   buf_ins;
    logic [WORD_W-1:0]   rd_word;
    logic                gnt_vld;
    logic [PORT_W-1:0]   gnt_port;
    logic [31:0]         gnt_addr;

    assign full    = (loaded_q == CNT_W'(DEPTH));
    assign rd_word = oor_q ? '0 : rdata_q;

    // Round-robin search starting at the port after the last grant.
    always_comb begin : arb
        int p;
        p        = 0;
        gnt_vld  = 1'b0;
        gnt_port = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            p = int'(prio_q) + i;
            if (p >= NUM_PORTS) p = p - NUM_PORTS;
            if (!gnt_vld && req_in[p]) begin
                gnt_vld  = 1'b1;
                gnt_port = PORT_W'(p);
            end
        end
        gnt_addr = addr_in[32*int'(gnt_port) +: 32];
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        buf_d     = buf_q;
        loaded_d  = loaded_q;
        err_d     = err_q;
        rcnt_d    = rcnt_q;
        prio_d    = prio_q;
        vld_d     = '0;
        oor_d     = oor_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = loaded_q[IDX_W-1:0];
        mem_wdata = buf_q;
        buf_ins   = buf_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            hold_d[p] = vld_q[p] ? rd_word : hold_q[p];
        end

        case (state_q)
            LOADING: begin
                if (byte_valid_in) begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        if (BIG_ENDIAN != 0)
                            buf_ins[8*(WORD_BYTES-1-int'(lane_q)) +: 8] = byte_in;
                        else
                            buf_ins[8*int'(lane_q) +: 8] = byte_in;
                        if (lane_q == 4'(WORD_BYTES-1)) begin
                            mem_we    = 1'b1;
                            mem_wdata = buf_ins;
                            loaded_d  = loaded_q + 1'b1;
                            lane_d    = '0;
                            buf_d     = '0;
                        end else begin
                            lane_d = lane_q + 1'b1;
                            buf_d  = buf_ins;
                        end
                    end
                end
                if (load_done_in) state_d = FLUSH;
            end
            FLUSH: begin
                // Unfilled lanes of the buffer are already zero.
                if (lane_q != '0 && !full) begin
                    mem_we   = 1'b1;
                    loaded_d = loaded_q + 1'b1;
                end
                lane_d  = '0;
                buf_d   = '0;
                rcnt_d  = '0;
                state_d = SYS_RESET;
            end
            SYS_RESET: begin
                if (rcnt_q == 32'(RST_CYCLES - 1)) state_d = SERVING;
                else                               rcnt_d  = rcnt_q + 32'd1;
            end
            SERVING: begin
                if (gnt_vld) begin
                    mem_re          = 1'b1;
                    mem_addr        = gnt_addr[OFF_W +: IDX_W];
                    oor_d           = (gnt_addr >> (OFF_W + IDX_W)) != 32'd0;
                    vld_d[gnt_port] = 1'b1;
                    prio_d          = (int'(gnt_port) == NUM_PORTS - 1) ? '0 : gnt_port + 1'b1;
                end
            end
            default: state_d = LOADING;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= LOADING;
            lane_q   <= '0;
            buf_q    <= '0;
            loaded_q <= '0;
            err_q    <= 1'b0;
            rcnt_q   <= '0;
            prio_q   <= '0;
            vld_q    <= '0;
            oor_q    <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) hold_q[p] <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            buf_q    <= buf_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            rcnt_q   <= rcnt_d;
            prio_q   <= prio_d;
            vld_q    <= vld_d;
            oor_q    <= oor_d;
            for (int p = 0; p < NUM_PORTS; p++) hold_q[p] <= hold_d[p];
        end
    end

    // Writes happen only while loading and reads only while serving: one port suffices.
    always_ff @(posedge clk_in) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) rdata_q <= mem[mem_addr];
    end

    assign sys_rst_out      = (state_q == SYS_RESET);
    assign loaded_words_out = loaded_q;
    assign load_error_out   = err_q;
    assign valid_out        = vld_q;

    always_comb begin
        instr_out = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            instr_out[p*WORD_W +: WORD_W] = vld_q[p] ? rd_word : hold_q[p];
        end
    end

endmodule

// File: tb/tb_program_memory_mp.sv
// Randomized bench for program_memory_mp: two instances (little-endian and
// big-endian/small-depth) fed one byte stream, checked against a word-level model.
module tb_program_memory_mp;

    localparam int DA = 8, NA = 2, RA = 1, LA = 3;
    localparam int DB = 4, NB = 3, RB = 3, LB = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bv = 1'b0;
    logic [7:0]   bi = 8'h00;
    logic         ld = 1'b0;
    logic [1:0]   req_a = '0;
    logic [63:0]  addr_a = '0;
    logic [2:0]   req_b = '0;
    logic [95:0]  addr_b = '0;
    logic         sro_a, sro_b, err_a, err_b;
    logic [3:0]   lw_a;
    logic [2:0]   lw_b;
    logic [63:0]  instr_a;
    logic [95:0]  instr_b;
    logic [1:0]   vld_a;
    logic [2:0]   vld_b;

    int checks = 0;
    int errors = 0;

    int          k = -1;
    int          nacc = 0;
    int          cnt_fa = 1, cnt_fb = 1;
    int          prio_a = 0, prio_b = 0;
    logic [7:0]  stim[$];
    logic [31:0] mem_a [DA];
    logic [31:0] mem_b [DB];
    logic [31:0] hold_a [NA];
    logic [31:0] hold_b [NB];

    always #5 clk = ~clk;

    program_memory_mp #(.WORD_BYTES(4), .DEPTH(DA), .NUM_PORTS(NA), .BIG_ENDIAN(0), .RST_CYCLES(RA)) dut_a (
        .clk_in(clk), .rst_in(rst), .byte_valid_in(bv), .byte_in(bi), .load_done_in(ld),
        .sys_rst_out(sro_a), .loaded_words_out(lw_a), .load_error_out(err_a),
        .req_in(req_a), .addr_in(addr_a), .instr_out(instr_a), .valid_out(vld_a));

    program_memory_mp #(.WORD_BYTES(4), .DEPTH(DB), .NUM_PORTS(NB), .BIG_ENDIAN(1), .RST_CYCLES(RB)) dut_b (
        .clk_in(clk), .rst_in(rst), .byte_valid_in(bv), .byte_in(bi), .load_done_in(ld),
        .sys_rst_out(sro_b), .loaded_words_out(lw_b), .load_error_out(err_b),
        .req_in(req_b), .addr_in(addr_b), .instr_out(instr_b), .valid_out(vld_b));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [31:0] model_word(input int j, input bit be);
        logic [31:0] w = '0;
        for (int b = 0; b < 4; b++)
            if (4*j + b < stim.size())
                w |= 32'(stim[4*j+b]) << (be ? 8*(3-b) : 8*b);
        return w;
    endfunction

    function automatic logic [31:0] rd_a(input logic [31:0] a);
        if ((a >> (2 + LA)) != 0) return '0;
        return mem_a[a[2 +: LA]];
    endfunction

    function automatic logic [31:0] rd_b(input logic [31:0] a);
        if ((a >> (2 + LB)) != 0) return '0;
        return mem_b[a[2 +: LB]];
    endfunction

    function automatic int rr_pick(input int req, input int prio, input int n);
        for (int i = 0; i < n; i++)
            if (req[(prio + i) % n]) return (prio + i) % n;
        return -1;
    endfunction

    function automatic logic [31:0] gen_addr(input int cnt);
        int r = $urandom_range(7);
        if (r == 0) return 32'h0001_0000;
        if (r == 1) return $urandom | 32'h8000_0000;
        return (32'($urandom_range(cnt - 1)) << 2) | 32'($urandom_range(3));
    endfunction

    task automatic rand_inputs();
        bv = 1'b0;
        ld = 1'b0;
        bi = 8'($urandom);
        req_a = 2'($urandom);
        req_b = 3'($urandom);
        for (int p = 0; p < NA; p++) addr_a[p*32 +: 32] = gen_addr(cnt_fa);
        for (int p = 0; p < NB; p++) addr_b[p*32 +: 32] = gen_addr(cnt_fb);
    endtask

    // One clock: model advances on the inputs sampled at this edge, then outputs are compared.
    task automatic tick();
        int kp, g;
        logic [63:0] ei_a;
        logic [95:0] ei_b;
        logic [1:0]  ev_a;
        logic [2:0]  ev_b;
        @(posedge clk);
        #1;
        kp = k;
        if (k < 0) begin
            if (bv) nacc++;
            if (ld) k = 0;
        end else begin
            k++;
        end
        if (k == 1) begin
            for (int j = 0; j < imin((nacc + 3) / 4, DA); j++) mem_a[j] = model_word(j, 1'b0);
            for (int j = 0; j < imin((nacc + 3) / 4, DB); j++) mem_b[j] = model_word(j, 1'b1);
        end
        ev_a = '0;
        ev_b = '0;
        if (kp >= RA + 1) begin
            g = rr_pick(int'(req_a), prio_a, NA);
            if (g >= 0) begin
                ev_a[g] = 1'b1;
                prio_a = (g + 1) % NA;
                hold_a[g] = rd_a(addr_a[g*32 +: 32]);
            end
        end
        if (kp >= RB + 1) begin
            g = rr_pick(int'(req_b), prio_b, NB);
            if (g >= 0) begin
                ev_b[g] = 1'b1;
                prio_b = (g + 1) % NB;
                hold_b[g] = rd_b(addr_b[g*32 +: 32]);
            end
        end
        for (int p = 0; p < NA; p++) ei_a[p*32 +: 32] = hold_a[p];
        for (int p = 0; p < NB; p++) ei_b[p*32 +: 32] = hold_b[p];
        chk("lw_a", lw_a, (k >= 1) ? imin((nacc + 3) / 4, DA) : imin(nacc / 4, DA));
        chk("lw_b", lw_b, (k >= 1) ? imin((nacc + 3) / 4, DB) : imin(nacc / 4, DB));
        chk("err_a", err_a, nacc > 4 * DA);
        chk("err_b", err_b, nacc > 4 * DB);
        chk("sro_a", sro_a, (k >= 1 && k <= RA));
        chk("sro_b", sro_b, (k >= 1 && k <= RB));
        chk("vld_a", vld_a, ev_a);
        chk("vld_b", vld_b, ev_b);
        chk("instr_a", instr_a, ei_a);
        chk("instr_b", instr_b, ei_b);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rand_inputs();
        bv = 1'($urandom);
        rst = 1'b1;
        @(posedge clk);
        #1;
        k = -1;
        nacc = 0;
        prio_a = 0;
        prio_b = 0;
        for (int p = 0; p < NA; p++) hold_a[p] = '0;
        for (int p = 0; p < NB; p++) hold_b[p] = '0;
        chk("rst_lw", {lw_a, lw_b}, '0);
        chk("rst_err", {err_a, err_b}, '0);
        chk("rst_sro", {sro_a, sro_b}, '0);
        chk("rst_vld", {vld_a, vld_b}, '0);
        chk("rst_instr", {instr_a, instr_b}, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_test(input int serve);
        int idx = 0;
        cnt_fa = imin((stim.size() + 3) / 4, DA);
        cnt_fb = imin((stim.size() + 3) / 4, DB);
        do_reset();
        while (idx < stim.size()) begin
            rand_inputs();
            bv = ($urandom_range(3) != 0);
            if (bv) bi = stim[idx];
            if (bv && idx == stim.size() - 1 && $urandom_range(1) == 1) ld = 1'b1;
            tick();
            if (bv) idx++;
        end
        if (k < 0) begin
            rand_inputs();
            ld = 1'b1;
            tick();
        end
        for (int i = 0; i < RB + 2 + serve; i++) begin
            rand_inputs();
            bv = 1'($urandom);
            ld = 1'($urandom);
            tick();
        end
    endtask

    task automatic rd_const(input string tag, input bit inst_b, input logic [31:0] a,
                            input logic [31:0] exp);
        rand_inputs();
        if (!inst_b) begin
            req_a = 2'b01;
            addr_a[31:0] = a;
        end else begin
            req_b = 3'b001;
            addr_b[31:0] = a;
        end
        tick();
        if (!inst_b) begin
            chk({tag, "_v"}, vld_a[0], 1'b1);
            chk(tag, instr_a[31:0], exp);
        end else begin
            chk({tag, "_v"}, vld_b[0], 1'b1);
            chk(tag, instr_b[31:0], exp);
        end
    endtask

    task automatic fairness();
        int ga [NA];
        int gb [NB];
        for (int p = 0; p < NA; p++) ga[p] = 0;
        for (int p = 0; p < NB; p++) gb[p] = 0;
        for (int c = 0; c < 6; c++) begin
            rand_inputs();
            req_a = '1;
            req_b = '1;
            tick();
            for (int p = 0; p < NA; p++) ga[p] += int'(vld_a[p]);
            for (int p = 0; p < NB; p++) gb[p] += int'(vld_b[p]);
        end
        for (int p = 0; p < NA; p++) chk("fair_a", ga[p], 3);
        for (int p = 0; p < NB; p++) chk("fair_b", gb[p], 2);
    endtask

    initial begin
        repeat (2) @(negedge clk);

        stim = {};
        for (int i = 1; i <= 8; i++) stim.push_back(8'(i));
        run_test(20);
        rd_const("le_w1", 1'b0, 32'd4, 32'h0807_0605);
        rd_const("be_w1", 1'b1, 32'd4, 32'h0506_0708);
        rd_const("oor_a", 1'b0, 32'h0001_0000, 32'h0);
        fairness();

        stim = {};
        for (int i = 1; i <= 6; i++) stim.push_back(8'(i));
        run_test(10);
        rd_const("be6_w0", 1'b1, 32'd0, 32'h0102_0304);
        rd_const("be6_w1", 1'b1, 32'd5, 32'h0506_0000);
        rd_const("le6_w1", 1'b0, 32'd7, 32'h0000_0605);

        stim = {};
        for (int i = 0; i < 20; i++) stim.push_back(8'($urandom));
        run_test(10);
        chk("full_lw_b", lw_b, 3'd4);
        chk("full_err_b", err_b, 1'b1);
        chk("full_lw_a", lw_a, 4'd5);
        rd_const("full_w3", 1'b1, 32'd12, {stim[12], stim[13], stim[14], stim[15]});

        do_reset();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            bv = 1'b1;
            tick();
        end
        stim = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_test(8);
        chk("mid_lw_a", lw_a, 4'd1);
        rd_const("mid_w0", 1'b0, 32'd0, 32'hDDCC_BBAA);

        for (int t = 0; t < 4; t++) begin
            stim = {};
            for (int i = 0; i < $urandom_range(1, 40); i++) stim.push_back(8'($urandom));
            run_test(30);
            fairness();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_memory_mp.md
PROGRAM_MEMORY_MP -- requirements
Module: program_memory_mp

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4, bytes per instruction word (1..8).
REQ-002 SHALL have parameter DEPTH, default 1024, words of storage (power of two).
REQ-003 SHALL have parameter NUM_PORTS, default 2, independent read channels (1..4).
REQ-004 SHALL have parameter BIG_ENDIAN, default 0, byte order used when packing the load stream into words.
REQ-005 SHALL have parameter RST_CYCLES, default 1, width of the sys_rst_out pulse (>=1).
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk_in  in  1  system clock.
REQ-008 rst_in  in  1  synchronous active-high reset.
REQ-009 byte_valid_in  in  1  load-stream byte strobe.
REQ-010 byte_in  in  8  load-stream byte.
REQ-011 load_done_in  in  1  one-cycle pulse: load stream finished.
REQ-012 sys_rst_out  out  1  system reset pulse, issued once loading completes.
REQ-013 loaded_words_out  out  $clog2(DEPTH)+1  count of words written.
REQ-014 load_error_out  out  1  sticky: stream exceeded capacity.
REQ-015 req_in  in  NUM_PORTS  per-port read request (level).
REQ-016 addr_in  in  NUM_PORTS*32  per-port byte address; port p at bits [32p+31:32p].
REQ-017 instr_out  out  NUM_PORTS*WORD_BYTES*8  per-port read data.
REQ-018 valid_out  out  NUM_PORTS  per-port one-cycle read-data strobe.

Function
REQ-019 SHALL implement states LOADING, FLUSH, SYS_RESET, SERVING; reset enters LOADING.
REQ-020 LOADING: each byte_valid_in byte SHALL fill the next byte lane; BIG_ENDIAN=0 -> first byte in bits[7:0], BIG_ENDIAN=1 -> first byte in MSB lane.
REQ-021 On the cycle the WORD_BYTES-th byte is accepted, the word SHALL be written at index loaded_words_out, which then increments by 1.
REQ-022 Bytes arriving when loaded_words_out == DEPTH SHALL be dropped and load_error_out set to 1 until rst_in.
REQ-023 load_done_in SHALL move to FLUSH; byte_valid_in in the same cycle SHALL be accepted first.
REQ-024 FLUSH (1 cycle): a partial word SHALL be written zero-padded in unfilled lanes and counted; with no partial word or memory full, nothing is written.
REQ-025 SYS_RESET: sys_rst_out SHALL be 1 for exactly RST_CYCLES cycles, then SERVING.
REQ-026 Bytes and load_done_in outside LOADING SHALL be ignored.
REQ-027 req_in SHALL be ignored outside SERVING; valid_out stays 0.
REQ-028 SERVING: one port granted per cycle among ports with req_in=1, round-robin starting after the last granted port; after reset port 0 has top priority.
REQ-029 Grant in cycle N SHALL produce valid_out[p]=1 in N+1 with the word at index addr_in[p][$clog2(WORD_BYTES)+:$clog2(DEPTH)] sampled in N.
REQ-030 Low $clog2(WORD_BYTES) address bits SHALL be ignored; word index >= DEPTH (upper address bits nonzero) SHALL return all-zero data, valid still asserted.
REQ-031 A port holding req_in high SHALL be re-arbitrated each cycle; one valid_out pulse per grant, no drops or duplicates.
REQ-032 instr_out[p] SHALL hold its last value until the next valid_out[p].
REQ-033 With all NUM_PORTS requesting continuously, each port SHALL receive one grant every NUM_PORTS cycles.
REQ-034 Storage SHALL be a single-ported synchronous array of DEPTH x WORD_BYTES*8 bits.

Reset
REQ-035 rst_in SHALL set: state LOADING, byte lane 0, loaded_words_out 0, load_error_out 0, sys_rst_out 0, valid_out 0, instr_out 0, round-robin pointer to port 0.
REQ-036 rst_in mid-load or mid-service SHALL discard partial word and in-flight reads; memory contents need not be cleared.

Verification
REQ-037 Stream 8 bytes 01..08, done -> words 0x04030201, 0x08070605; loaded_words_out=2; sys_rst_out high 1 cycle; read addr 4 -> 0x08070605 one cycle later.
REQ-038 BIG_ENDIAN=1, 6 bytes 01..06, done -> word0=0x01020304, word1=0x05060000 (flushed); loaded_words_out=2.
REQ-039 DEPTH=4, 20 bytes -> loaded_words_out=4, load_error_out=1, last 4 bytes absent.
REQ-040 Both ports request continuously -> grants alternate 0,1,0,1; each valid_out one cycle after its grant, correct data each.
REQ-041 req_in during LOADING -> no valid_out; addr_in=0x0001_0000 in SERVING -> instr_out=0, valid_out=1.
REQ-042 rst_in mid-stream after 3 bytes, then 4 new bytes AA..DD -> word0=0xDDCCBBAA, loaded_words_out=1.
